deserializer: RTL and testbench

- Receive-side counterpart of the router's frame serializer. Consumes Aurora AXI-Stream RX beats: one header beat, then 17 payload beats.
- Reassembles the 1024-bit payload and recovers the header fields (dst_addr, TTL, router_id).
- Presents the result to the router ingress logic as a registered, single-cycle-valid packet.
- Sits between the Aurora RX user interface and the router input buffer.

---
 rtl/deserializer_pkg.sv | 34 +++
 rtl/deserializer_if.sv | 27 ++
 rtl/deserializer_header_decode.sv | 19 +
 rtl/deserializer.sv | 112 +++++++++++
 tb/tb_deserializer.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/deserializer_pkg.sv
// Shared constants, field offsets and types for the Aurora frame serializer/deserializer pair.
// A frame is one header beat followed by NUMBER_PACKET payload beats.
package deserializer_pkg;

    localparam int NUMER_OF_LANE          = 1;
    localparam int AURORA_DATA_WIDTH      = 64 * NUMER_OF_LANE;
    localparam int SEND_DATA_WIDTH        = 1024;
    localparam int RECOGNIZE_HEADER_WIDTH = 1;
    localparam int RECOGNIZE_ROUTER_WIDTH = 2;
    localparam int HOST_PAYLOAD_WIDTH     = AURORA_DATA_WIDTH - 3;
    localparam int NUMBER_PACKET          = SEND_DATA_WIDTH / HOST_PAYLOAD_WIDTH + 1;
    localparam int LAST_PAYLOAD_WIDTH     = SEND_DATA_WIDTH - (NUMBER_PACKET - 1) * HOST_PAYLOAD_WIDTH;
    localparam int ADDR_WIDTH             = 10;
    localparam int TTL_WIDTH              = 2;
    localparam int CNT_WIDTH              = $clog2(NUMBER_PACKET + 1);

    localparam int FLAG_BIT = 0;
    localparam int RID_LSB  = 1;
    localparam int TTL_LSB  = 3;
    localparam int DST_LSB  = 5;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        RECV_PAYLOAD = 2'd1,
        DONE         = 2'd2
    } deser_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]             dst;
        logic [TTL_WIDTH-1:0]              ttl;
        logic [RECOGNIZE_ROUTER_WIDTH-1:0] rid;
    } hdr_fields_t;

endpackage

// File: rtl/deserializer_if.sv
// Aurora RX beat stream in, reassembled packet out.
// axis_rx_tvalid qualifies a beat and has no ready: every beat with tvalid high at a rising edge
// is consumed. recv_data_valid and frame_error are single-cycle pulses with no acknowledge.
interface deserializer_if
    import deserializer_pkg::*;
();
    logic                              axis_rx_tvalid;
    logic                              axis_rx_tlast;
    logic [AURORA_DATA_WIDTH-1:0]      axis_rx_tdata;

    logic                              recv_data_valid;
    logic [SEND_DATA_WIDTH-1:0]        v_data_write;
    logic [ADDR_WIDTH-1:0]             dst_addr_recv;
    logic [TTL_WIDTH-1:0]              TTL_recv;
    logic [RECOGNIZE_ROUTER_WIDTH-1:0] router_id_recv;
    logic                              frame_error;

    modport master (
        output axis_rx_tvalid, axis_rx_tlast, axis_rx_tdata,
        input  recv_data_valid, v_data_write, dst_addr_recv, TTL_recv, router_id_recv, frame_error
    );

    modport slave (
        input  axis_rx_tvalid, axis_rx_tlast, axis_rx_tdata,
        output recv_data_valid, v_data_write, dst_addr_recv, TTL_recv, router_id_recv, frame_error
    );
endinterface

// File: rtl/deserializer_header_decode.sv
// Combinational decode of the low beat bits: header flag, header fields and router_id match
// against the router_id latched from the frame's header.
module deser_header_decode
    import deserializer_pkg::*;
(
    input  logic [DST_LSB+ADDR_WIDTH-1:0]     hdr_bits_i,
    input  logic [RECOGNIZE_ROUTER_WIDTH-1:0] latched_rid_i,
    output logic                              is_header_o,
    output hdr_fields_t                       fields_o,
    output logic                              rid_match_o
);
    assign is_header_o = hdr_bits_i[FLAG_BIT +: RECOGNIZE_HEADER_WIDTH];

    assign fields_o = {hdr_bits_i[DST_LSB +: ADDR_WIDTH],
                       hdr_bits_i[TTL_LSB +: TTL_WIDTH],
                       hdr_bits_i[RID_LSB +: RECOGNIZE_ROUTER_WIDTH]};

    assign rid_match_o = (hdr_bits_i[RID_LSB +: RECOGNIZE_ROUTER_WIDTH] == latched_rid_i);
endmodule

// File: rtl/deserializer.sv
// Reassembles one header beat plus 17 payload beats into a 1024-bit packet with header fields,
// delivered as a registered one-cycle pulse; malformed frames are dropped with frame_error.
module deserializer
    import deserializer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    deserializer_if.slave rx,
    output deser_state_e  state_o
);
    localparam int ASM_WIDTH = (NUMBER_PACKET - 1) * HOST_PAYLOAD_WIDTH;

    deser_state_e               state_q;
    logic [CNT_WIDTH-1:0]       cnt_q;
    logic [CNT_WIDTH-1:0]       cnt_d;
    logic [ASM_WIDTH-1:0]       asm_q;
    hdr_fields_t                hdr_q;
    hdr_fields_t                out_hdr_q;
    logic [SEND_DATA_WIDTH-1:0] data_q;
    logic                       valid_q;
    logic                       err_q;

    logic                          is_header;
    logic                          rid_match;
    hdr_fields_t                   beat_fields;
    logic [HOST_PAYLOAD_WIDTH-1:0] beat_payload;

    assign beat_payload = rx.axis_rx_tdata[AURORA_DATA_WIDTH-1 -: HOST_PAYLOAD_WIDTH];
    assign cnt_d        = cnt_q + CNT_WIDTH'(1);

    deser_header_decode u_decode (
        .hdr_bits_i    (rx.axis_rx_tdata[DST_LSB+ADDR_WIDTH-1:0]),
        .latched_rid_i (hdr_q.rid),
        .is_header_o   (is_header),
        .fields_o      (beat_fields),
        .rid_match_o   (rid_match)
    );

    // DONE accepts a new beat exactly like IDLE so back-to-back frames lose nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            asm_q     <= '0;
            hdr_q     <= '0;
            out_hdr_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (rx.axis_rx_tvalid) begin
                        if (is_header && !rx.axis_rx_tlast) begin
                            hdr_q   <= beat_fields;
                            cnt_q   <= CNT_WIDTH'(1);
                            state_q <= RECV_PAYLOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RECV_PAYLOAD: begin
                    if (rx.axis_rx_tvalid) begin
                        if (is_header) begin
                            // Resync: the partial frame is dropped and the new header restarts assembly.
                            err_q <= 1'b1;
                            if (rx.axis_rx_tlast) begin
                                state_q <= IDLE;
                            end else begin
                                hdr_q <= beat_fields;
                                cnt_q <= CNT_WIDTH'(1);
                            end
                        end else if (!rid_match) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else if (cnt_q == CNT_WIDTH'(NUMBER_PACKET)) begin
                            if (rx.axis_rx_tlast) begin
                                data_q    <= {rx.axis_rx_tdata[LAST_PAYLOAD_WIDTH+2:3], asm_q};
                                out_hdr_q <= hdr_q;
                                valid_q   <= 1'b1;
                                state_q   <= DONE;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                        end else if (rx.axis_rx_tlast) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            asm_q[(int'(cnt_q) - 1) * HOST_PAYLOAD_WIDTH +: HOST_PAYLOAD_WIDTH] <= beat_payload;
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx.recv_data_valid = valid_q;
    assign rx.frame_error     = err_q;
    assign rx.v_data_write    = data_q;
    assign rx.dst_addr_recv   = out_hdr_q.dst;
    assign rx.TTL_recv        = out_hdr_q.ttl;
    assign rx.router_id_recv  = out_hdr_q.rid;
    assign state_o            = state_q;

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for the frame deserializer: table-driven frame shapes, hand-written
// corner sequences and random frames, all checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_deserializer;
  import deserializer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  deser_state_e rx_state;
  deserializer_if rx_if ();

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  deserializer dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx_if),
    .state_o (rx_state)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int cnt_valid = 0;
  int cnt_err   = 0;
  int valid_times[$];
  logic [SEND_DATA_WIDTH-1:0] exp_q[$];

  // reference model state: frame-level, beats kept as a list
  bit          m_in_frame;
  logic [63:0] m_beats[$];
  logic [9:0]  m_dst;
  logic [1:0]  m_ttl;
  logic [1:0]  m_rid;
  logic        e_valid, e_err;
  logic [SEND_DATA_WIDTH-1:0] e_data;
  logic [9:0]  e_dst;
  logic [1:0]  e_ttl, e_rid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_data(input string name, input logic [SEND_DATA_WIDTH-1:0] act,
                          input logic [SEND_DATA_WIDTH-1:0] exp);
    int idx;
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      idx = -1;
      for (int i = 0; i < SEND_DATA_WIDTH; i++) begin
        if (act[i] !== exp[i] && idx < 0) idx = i;
      end
      $display("FAIL %s: first bad bit %0d got %b expected %b; low word got %h expected %h (cycle %0d)",
               name, idx, act[idx], exp[idx], act[63:0], exp[63:0], cyc);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_in_frame = 0;
    m_beats.delete();
    exp_q.delete();
    e_valid = 0; e_err = 0; e_data = '0; e_dst = '0; e_ttl = '0; e_rid = '0;
  endtask

  task automatic model_start(input logic [63:0] d);
    m_in_frame = 1;
    m_beats.delete();
    m_rid = d[2:1];
    m_ttl = d[4:3];
    m_dst = d[14:5];
  endtask

  // Payload is the concatenation of each beat's 61-bit field, first beat least significant,
  // truncated to 1024 bits (the surplus top bits of the 17th beat fall off).
  task automatic model_complete();
    logic [17*61-1:0] acc;
    acc = '0;
    for (int i = 16; i >= 0; i--) acc = (acc << 61) | (17*61)'(m_beats[i][63:3]);
    e_data  = acc[SEND_DATA_WIDTH-1:0];
    e_dst   = m_dst;
    e_ttl   = m_ttl;
    e_rid   = m_rid;
    e_valid = 1;
    exp_q.push_back(e_data);
    m_in_frame = 0;
  endtask

  task automatic model_step(input logic v, input logic l, input logic [63:0] d);
    e_valid = 0;
    e_err   = 0;
    if (v) begin
      if (!m_in_frame) begin
        if (d[0] && !l) model_start(d);
        else e_err = 1;
      end else if (d[0]) begin
        e_err = 1;
        if (l) m_in_frame = 0;
        else model_start(d);
      end else if (d[2:1] != m_rid) begin
        e_err = 1;
        m_in_frame = 0;
      end else begin
        m_beats.push_back(d);
        if (m_beats.size() == 17 && l) model_complete();
        else if (l || m_beats.size() == 17) begin
          e_err = 1;
          m_in_frame = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [SEND_DATA_WIDTH-1:0] e;
    if (rx_if.recv_data_valid === 1'b1) begin
      cnt_valid++;
      valid_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL scoreboard: got a frame, expected none (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk_data("scoreboard payload", rx_if.v_data_write, e);
      end
    end
    if (rx_if.frame_error === 1'b1) cnt_err++;
    chk("recv_data_valid", 64'(rx_if.recv_data_valid), 64'(e_valid));
    chk("frame_error", 64'(rx_if.frame_error), 64'(e_err));
    chk("dst_addr_recv", 64'(rx_if.dst_addr_recv), 64'(e_dst));
    chk("TTL_recv", 64'(rx_if.TTL_recv), 64'(e_ttl));
    chk("router_id_recv", 64'(rx_if.router_id_recv), 64'(e_rid));
    chk_data("v_data_write", rx_if.v_data_write, e_data);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic v, input logic l, input logic [63:0] d);
    rx_if.axis_rx_tvalid = v;
    rx_if.axis_rx_tlast  = l;
    rx_if.axis_rx_tdata  = d;
    @(posedge clk);
    cyc++;
    model_step(v, l, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    cycle(1'b0, 1'($urandom), {$urandom, $urandom});
  endtask

  task automatic do_reset(input logic v, input logic l, input logic [63:0] d);
    rst = 1'b1;
    rx_if.axis_rx_tvalid = v;
    rx_if.axis_rx_tlast  = l;
    rx_if.axis_rx_tdata  = d;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    check_outputs();
    chk("reset state", 64'(rx_state), 64'(IDLE));
    chk("reset frame_error", 64'(rx_if.frame_error), 64'(0));
    chk_data("reset v_data_write", rx_if.v_data_write, '0);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] mk_hdr(input logic [9:0] dst, input logic [1:0] ttl, input logic [1:0] rid);
    logic [48:0] junk;
    junk = 49'({$urandom, $urandom});
    return {junk, dst, ttl, rid, 1'b1};
  endfunction

  function automatic logic [63:0] beat_of(input logic [SEND_DATA_WIDTH-1:0] pl, input int k, input logic [1:0] rid);
    logic [60:0] s;
    if (k >= 17) s = {13'h15A5, pl[1023:976]};
    else s = pl[61*k-1 -: 61];
    return {s, rid, 1'b0};
  endfunction

  function automatic logic [SEND_DATA_WIDTH-1:0] rand_payload();
    logic [SEND_DATA_WIDTH-1:0] pl;
    for (int i = 0; i < 32; i++) pl[i*32 +: 32] = $urandom;
    return pl;
  endfunction

  // tlast_on: 0 = tlast on the header, -1 = never, k = payload beat k
  task automatic send_frame(input logic [63:0] h, input logic [SEND_DATA_WIDTH-1:0] pl, input int n_pay,
                            input int tlast_on, input int bad_at, input int gap_pct);
    logic [1:0] rid;
    rid = h[2:1];
    cycle(1'b1, tlast_on == 0, h);
    for (int k = 1; k <= n_pay; k++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 3)) idle();
      cycle(1'b1, k == tlast_on, beat_of(pl, k, (k == bad_at) ? ~rid : rid));
    end
  endtask

  // ---------------- test ----------------
  typedef struct {
    string name;
    int    n_pay;
    int    tlast_on;
    int    bad_at;
    int    exp_valid;
    int    exp_err;
  } frame_vec_t;

  frame_vec_t tv[8];
  logic [SEND_DATA_WIDTH-1:0] pat, pl2;
  logic [63:0] h2;
  int kind, n;

  initial begin
    tv[0] = '{"good",        17, 17, 0, 1, 0};
    tv[1] = '{"short9",       9,  9, 0, 0, 1};
    tv[2] = '{"hdr_tlast",    0,  0, 0, 0, 1};
    tv[3] = '{"tlast_beat1",  1,  1, 0, 0, 1};
    tv[4] = '{"no_tlast17",  17, -1, 0, 0, 1};
    tv[5] = '{"overlong18",  18, 18, 0, 0, 2};
    tv[6] = '{"bad_rid4",    17, 17, 4, 0, 14};
    tv[7] = '{"bad_rid17",   17, 17, 17, 0, 1};
    for (int i = 0; i < SEND_DATA_WIDTH; i++) pat[i] = 1'(i % 2);

    rx_if.axis_rx_tvalid = 1'b0;
    rx_if.axis_rx_tlast  = 1'b0;
    rx_if.axis_rx_tdata  = '0;
    do_reset(1'b0, 1'b0, 64'h0);
    chk("reset recv_data_valid", 64'(rx_if.recv_data_valid), 64'(0));
    chk("reset dst_addr_recv", 64'(rx_if.dst_addr_recv), 64'(0));

    // A: good frame, no gaps
    cnt_err = 0;
    send_frame(64'h54B3, pat, 17, 17, 0, 0);
    chk("A valid after tlast", 64'(rx_if.recv_data_valid), 64'(1));
    chk_data("A payload", rx_if.v_data_write, pat);
    chk("A dst", 64'(rx_if.dst_addr_recv), 64'h2A5);
    chk("A ttl", 64'(rx_if.TTL_recv), 64'(2));
    chk("A rid", 64'(rx_if.router_id_recv), 64'(1));
    idle();
    chk("A valid single cycle", 64'(rx_if.recv_data_valid), 64'(0));
    chk("A no frame_error", 64'(cnt_err), 64'(0));

    // B: same frame with gaps (3 idle after beat 5, 1 idle before tlast)
    cnt_valid = 0;
    cycle(1'b1, 1'b0, 64'h54B3);
    for (int k = 1; k <= 17; k++) begin
      if (k == 6) repeat (3) idle();
      if (k == 17) idle();
      cycle(1'b1, k == 17, beat_of(pat, k, 2'b01));
    end
    chk("B valid after tlast", 64'(rx_if.recv_data_valid), 64'(1));
    chk_data("B payload", rx_if.v_data_write, pat);
    chk("B dst", 64'(rx_if.dst_addr_recv), 64'h2A5);

    // C: tlast on payload beat 9, then a good frame
    send_frame(64'h54B3, ~pat, 9, 9, 0, 0);
    chk("C frame_error", 64'(rx_if.frame_error), 64'(1));
    chk("C no valid", 64'(rx_if.recv_data_valid), 64'(0));
    chk_data("C outputs held", rx_if.v_data_write, pat);
    pl2 = rand_payload();
    send_frame(mk_hdr(10'h0F1, 2'b01, 2'b10), pl2, 17, 17, 0, 0);
    chk_data("C recovery payload", rx_if.v_data_write, pl2);

    // D: new header at payload beat 12 (resync)
    send_frame(64'h54B3, pat, 11, -1, 0, 0);
    h2 = {49'h0, 10'h13C, 2'b01, 2'b11, 1'b1};
    cycle(1'b1, 1'b0, h2);
    chk("D resync frame_error", 64'(rx_if.frame_error), 64'(1));
    for (int k = 1; k <= 17; k++) cycle(1'b1, k == 17, beat_of(pl2 ^ pat, k, 2'b11));
    chk("D valid", 64'(rx_if.recv_data_valid), 64'(1));
    chk("D dst", 64'(rx_if.dst_addr_recv), 64'h13C);
    chk("D ttl", 64'(rx_if.TTL_recv), 64'(1));
    chk("D rid", 64'(rx_if.router_id_recv), 64'(3));
    chk_data("D payload", rx_if.v_data_write, pl2 ^ pat);

    // E: back-to-back frames, second header in the DONE cycle
    valid_times.delete();
    send_frame(64'h54B3, pat, 17, 17, 0, 0);
    send_frame(h2, ~pat, 17, 17, 0, 0);
    chk("E two pulses", 64'(valid_times.size()), 64'(2));
    if (valid_times.size() == 2) chk("E pulse spacing", 64'(valid_times[1] - valid_times[0]), 64'(18));
    chk_data("E second payload", rx_if.v_data_write, ~pat);

    // F: reset at payload beat 7, then a good frame
    cnt_err = 0;
    send_frame(64'h54B3, pat, 6, -1, 0, 0);
    do_reset(1'b1, 1'b0, beat_of(pat, 7, 2'b01));
    chk("F no frame_error", 64'(cnt_err), 64'(0));
    chk("F dst cleared", 64'(rx_if.dst_addr_recv), 64'(0));
    for (int k = 8; k <= 9; k++) cycle(1'b1, 1'b0, beat_of(pat, k, 2'b01));
    send_frame(64'h54B3, pat, 17, 17, 0, 0);
    chk_data("F recovery payload", rx_if.v_data_write, pat);

    // table of frame shapes: pulse counts per frame
    for (int i = 0; i < 8; i++) begin
      cnt_valid = 0;
      cnt_err   = 0;
      send_frame(mk_hdr(10'($urandom), 2'($urandom), 2'($urandom)), rand_payload(),
                 tv[i].n_pay, tv[i].tlast_on, tv[i].bad_at, 20);
      idle();
      idle();
      chk({tv[i].name, " valid count"}, 64'(cnt_valid), 64'(tv[i].exp_valid));
      chk({tv[i].name, " error count"}, 64'(cnt_err), 64'(tv[i].exp_err));
    end

    // random frames, mostly good, with gaps and faults
    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 9);
      n = $urandom_range(1, 16);
      case (kind)
        6: send_frame(mk_hdr(10'($urandom), 2'($urandom), 2'($urandom)), rand_payload(), n, n, 0, 25);
        7: send_frame(mk_hdr(10'($urandom), 2'($urandom), 2'($urandom)), rand_payload(), 17, 17,
                      $urandom_range(1, 17), 25);
        8: send_frame(mk_hdr(10'($urandom), 2'($urandom), 2'($urandom)), rand_payload(), n, -1, 0, 25);
        9: cycle(1'b1, 1'($urandom), {$urandom, 29'($urandom), 2'($urandom), 1'b0});
        default: send_frame(mk_hdr(10'($urandom), 2'($urandom), 2'($urandom)), rand_payload(), 17, 17, 0, 25);
      endcase
      if ($urandom_range(0, 3) == 0) idle();
    end
    repeat (4) idle();
    chk("scoreboard drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
